// File: rtl/control_unit.sv
// control_unit: multi-cycle sequencer producing the 20-bit datapath control word.
// Control word: {addr_a[19:16], addr_b[15:12], addr_d[11:8], fr_rw[7], sel_d[6], psr_rw[5], d[4], fu_op[3:0]}.
// Optional feature macro: CU_MEM_TIMEOUT_EN (bounded memory waits with sticky fault state).
module control_unit #(
  parameter logic [3:0] FU_INC   = 4'h8,
  parameter logic [3:0] FU_PASSA = 4'h0
`ifdef CU_MEM_TIMEOUT_EN
  , parameter int unsigned TIMEOUT = 16
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instruction,
  input  logic [4:0]  status,
  input  logic        mem_ready,
  output logic [19:0] ctrlword,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        halted,
  output logic        fault,
  output logic [2:0]  state_dbg
);

  localparam logic [3:0] REG_PC    = 4'd14;
  localparam logic [3:0] REG_IR    = 4'd15;
  localparam logic [3:0] OP_LOAD   = 4'hC;
  localparam logic [3:0] OP_STORE  = 4'hD;
  localparam logic [3:0] OP_BRANCH = 4'hE;
  localparam logic [3:0] OP_HALT   = 4'hF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    INCPC  = 3'd2,
    DECODE = 3'd3,
    EXEC   = 3'd4,
    HALT   = 3'd5,
    FAULT  = 3'd6
  } state_t;

  state_t state, next;

  logic [3:0] op, rd, rs1, rs2;
  logic [3:0] addr_a, addr_b, addr_d, fu_op;
  logic       fr_rw, sel_d, psr_rw, taken;
  logic       unused_status_d;

  assign op  = instruction[15:12];
  assign rd  = instruction[11:8];
  assign rs1 = instruction[7:4];
  assign rs2 = instruction[3:0];

  // The D flag takes no part in branch conditions
  assign unused_status_d = status[4];

  assign ctrlword  = {addr_a, addr_b, addr_d, fr_rw, sel_d, psr_rw, 1'b0, fu_op};
  assign state_dbg = state;

`ifdef CU_MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             in_wait;
  logic             timeout_hit;

  assign in_wait = (state == FETCH) ||
                   ((state == EXEC) && ((op == OP_LOAD) || (op == OP_STORE)));
  assign timeout_hit = in_wait && !mem_ready && (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign fault = (state == FAULT);

  // Wait-cycle counter: cleared on every state change, counts stalled cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (state != next) begin
      wait_cnt <= '0;
    end else if (in_wait && !mem_ready) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end
`else
  assign fault = 1'b0;
`endif

  // State register; asserting reset aborts any instruction in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next;
    end
  end

  // Branch condition decode from the rd/cond field
  always_comb begin
    taken = 1'b0;
    case (rd)
      4'd0:    taken = 1'b1;
      4'd1:    taken = status[0];
      4'd2:    taken = !status[0];
      4'd3:    taken = status[1];
      4'd4:    taken = status[2];
      4'd5:    taken = status[3];
      default: taken = 1'b0;
    endcase
  end

  // Next-state and control-word decode
  always_comb begin
    next   = state;
    addr_a = 4'd0;
    addr_b = 4'd0;
    addr_d = 4'd0;
    fu_op  = 4'd0;
    fr_rw  = 1'b0;
    sel_d  = 1'b0;
    psr_rw = 1'b0;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    halted = 1'b0;

    case (state)
      IDLE: next = FETCH;

      FETCH: begin
        addr_a = REG_PC;
        mem_rd = 1'b1;
        if (mem_ready) begin
          addr_d = REG_IR;
          fr_rw  = 1'b1;
          sel_d  = 1'b1;
          next   = INCPC;
        end
      end

      INCPC: begin
        addr_a = REG_PC;
        fu_op  = FU_INC;
        addr_d = REG_PC;
        fr_rw  = 1'b1;
        next   = DECODE;
      end

      DECODE: next = EXEC;

      EXEC: begin
        case (op)
          OP_LOAD: begin
            addr_a = rs1;
            mem_rd = 1'b1;
            if (mem_ready) begin
              addr_d = rd;
              fr_rw  = (rd != REG_IR);
              sel_d  = 1'b1;
              next   = FETCH;
            end
          end
          OP_STORE: begin
            addr_a = rs1;
            addr_b = rs2;
            mem_wr = 1'b1;
            if (mem_ready) begin
              next = FETCH;
            end
          end
          OP_BRANCH: begin
            if (taken) begin
              addr_a = rs1;
              fu_op  = FU_PASSA;
              addr_d = REG_PC;
              fr_rw  = 1'b1;
            end
            next = FETCH;
          end
          OP_HALT: next = HALT;
          default: begin
            // ALU: a write to IR is suppressed, flags still update
            addr_a = rs1;
            addr_b = rs2;
            addr_d = rd;
            fu_op  = op;
            fr_rw  = (rd != REG_IR);
            psr_rw = 1'b1;
            next   = FETCH;
          end
        endcase
      end

      HALT: halted = 1'b1;

      FAULT: next = FAULT;

      default: next = IDLE;
    endcase

`ifdef CU_MEM_TIMEOUT_EN
    if (timeout_hit) begin
      next = FAULT;
    end
`endif
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed vectors with a queue-based scoreboard for control_unit.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instruction;
  logic [4:0]  status;
  logic        mem_ready;
  logic [19:0] ctrlword;
  logic        mem_rd, mem_wr, halted, fault;
  logic [2:0]  state_dbg;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_INCPC = 3'd2, S_DECODE = 3'd3,
                         S_EXEC = 3'd4, S_HALT = 3'd5, S_FAULT = 3'd6;

  typedef logic [26:0] exp_t;

  exp_t  expq[$];
  string nameq[$];
  int    vectors = 0;
  int    errors  = 0;

  control_unit dut (
    .clk(clk), .reset(reset), .instruction(instruction), .status(status),
    .mem_ready(mem_ready), .ctrlword(ctrlword), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .halted(halted), .fault(fault), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [2:0] st, input logic [19:0] cw,
                              input logic r, input logic w, input logic h, input logic f);
    return {st, cw, r, w, h, f};
  endfunction

  // Queue an expectation for the current cycle
  task automatic chk(input string nm, input exp_t e);
    expq.push_back(e);
    nameq.push_back(nm);
  endtask

  // Advance one cycle, drive inputs, queue the expected outputs for that cycle
  task automatic step(input string nm, input logic [15:0] ins, input logic [4:0] st,
                      input logic rdy, input exp_t e);
    @(posedge clk);
    #1;
    instruction = ins;
    status      = st;
    mem_ready   = rdy;
    chk(nm, e);
  endtask

  // FETCH (zero-wait), INCPC, DECODE; mem_ready low where it must be ignored
  task automatic front(input string nm, input logic [15:0] ins);
    step({nm, "_fetch"},  ins, 5'd0, 1'b1, mk(S_FETCH,  20'hE0FC0, 1'b1, 1'b0, 1'b0, 1'b0));
    step({nm, "_incpc"},  ins, 5'd0, 1'b0, mk(S_INCPC,  20'hE0E88, 1'b0, 1'b0, 1'b0, 1'b0));
    step({nm, "_decode"}, ins, 5'd0, 1'b0, mk(S_DECODE, 20'h00000, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  // Monitor: compare DUT outputs mid-cycle against the oldest expectation
  exp_t  mon_exp, mon_act;
  string mon_nm;
  always @(negedge clk) begin
    if (expq.size() != 0) begin
      mon_exp = expq.pop_front();
      mon_nm  = nameq.pop_front();
      mon_act = {state_dbg, ctrlword, mem_rd, mem_wr, halted, fault};
      vectors++;
      if (mon_act !== mon_exp) begin
        errors++;
        $display("FAIL %s: got st=%0d cw=%05h rd=%b wr=%b h=%b f=%b, want st=%0d cw=%05h rd=%b wr=%b h=%b f=%b",
                 mon_nm, mon_act[26:24], mon_act[23:4], mon_act[3], mon_act[2], mon_act[1], mon_act[0],
                 mon_exp[26:24], mon_exp[23:4], mon_exp[3], mon_exp[2], mon_exp[1], mon_exp[0]);
      end
    end
  end

  exp_t zero_idle;

  initial begin
    zero_idle   = mk(S_IDLE, 20'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset       = 1'b0;
    instruction = 16'h3123;
    status      = 5'd0;
    mem_ready   = 1'b1;

    // Reset and release
    @(posedge clk); #1; chk("reset", zero_idle);
    @(posedge clk); #1; reset = 1'b1; chk("idle_release", zero_idle);

    // ALU 3123 with zero-wait fetch
    front("alu", 16'h3123);
    step("alu_exec", 16'h3123, 5'd0, 1'b1, mk(S_EXEC, 20'h231A3, 1'b0, 1'b0, 1'b0, 1'b0));

    // Fetch wait cycle, then ALU writing R15: write suppressed, PSR still written
    step("fetch_wait", 16'h5F12, 5'd0, 1'b0, mk(S_FETCH, 20'hE0000, 1'b1, 1'b0, 1'b0, 1'b0));
    front("alu_r15", 16'h5F12);
    step("alu_r15_exec", 16'h5F12, 5'd0, 1'b1, mk(S_EXEC, 20'h12F25, 1'b0, 1'b0, 1'b0, 1'b0));

    // LOAD C450 with three wait cycles
    front("load", 16'hC450);
    for (int i = 0; i < 3; i++)
      step("load_wait", 16'hC450, 5'd0, 1'b0, mk(S_EXEC, 20'h50000, 1'b1, 1'b0, 1'b0, 1'b0));
    step("load_ready", 16'hC450, 5'd0, 1'b1, mk(S_EXEC, 20'h504C0, 1'b1, 1'b0, 1'b0, 1'b0));

    // STORE D067 with one wait cycle
    front("store", 16'hD067);
    step("store_wait",  16'hD067, 5'd0, 1'b0, mk(S_EXEC, 20'h67000, 1'b0, 1'b1, 1'b0, 1'b0));
    step("store_ready", 16'hD067, 5'd0, 1'b1, mk(S_EXEC, 20'h67000, 1'b0, 1'b1, 1'b0, 1'b0));

    // Branches: Z taken / not taken, N taken, never
    front("br_z1", 16'hE190);
    step("br_z1_exec", 16'hE190, 5'b00001, 1'b1, mk(S_EXEC, 20'h90E80, 1'b0, 1'b0, 1'b0, 1'b0));
    front("br_z0", 16'hE190);
    step("br_z0_exec", 16'hE190, 5'b11110, 1'b1, mk(S_EXEC, 20'h00000, 1'b0, 1'b0, 1'b0, 1'b0));
    front("br_n", 16'hE390);
    step("br_n_exec", 16'hE390, 5'b00010, 1'b1, mk(S_EXEC, 20'h90E80, 1'b0, 1'b0, 1'b0, 1'b0));
    front("br_never", 16'hE690);
    step("br_never_exec", 16'hE690, 5'b11111, 1'b1, mk(S_EXEC, 20'h00000, 1'b0, 1'b0, 1'b0, 1'b0));

`ifdef CU_MEM_TIMEOUT_EN
    // Fetch stalls: fault after 16 stalled cycles, sticky
    for (int i = 0; i < 16; i++)
      step("fetch_stall", 16'h0000, 5'd0, 1'b0, mk(S_FETCH, 20'hE0000, 1'b1, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++)
      step("fault_sticky", 16'h0000, 5'd0, i[0], mk(S_FAULT, 20'h0, 1'b0, 1'b0, 1'b0, 1'b1));
`else
    // Fetch stalls: unbounded wait, request held stable
    for (int i = 0; i < 20; i++)
      step("fetch_stall", 16'h0000, 5'd0, 1'b0, mk(S_FETCH, 20'hE0000, 1'b1, 1'b0, 1'b0, 1'b0));
`endif
    @(posedge clk); #1; reset = 1'b0; chk("reset_from_stall", zero_idle);
    @(posedge clk); #1; reset = 1'b1; chk("idle_release2", zero_idle);

    // HALT persists
    front("halt", 16'hF000);
    step("halt_exec", 16'hF000, 5'd0, 1'b1, mk(S_EXEC, 20'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 100; i++)
      step("halted", 16'hC450, 5'b11111, i[0], mk(S_HALT, 20'h0, 1'b0, 1'b0, 1'b1, 1'b0));

    // Leave HALT via reset, then abort a LOAD mid-wait
    @(posedge clk); #1; reset = 1'b0; chk("reset_from_halt", zero_idle);
    @(posedge clk); #1; reset = 1'b1; chk("idle_release3", zero_idle);
    front("load2", 16'hC450);
    step("load2_wait", 16'hC450, 5'd0, 1'b0, mk(S_EXEC, 20'h50000, 1'b1, 1'b0, 1'b0, 1'b0));
    @(posedge clk); #1; reset = 1'b0; mem_ready = 1'b1; chk("reset_mid_load", zero_idle);
    @(posedge clk); #1; chk("reset_held", zero_idle);
    @(posedge clk); #1; reset = 1'b1; chk("idle_release4", zero_idle);
    step("restart_fetch", 16'h3123, 5'd0, 1'b1, mk(S_FETCH, 20'hE0FC0, 1'b1, 1'b0, 1'b0, 1'b0));

    repeat (2) @(posedge clk);
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
